conv3x3_rgb888: RTL and testbench
=================================

# conv3x3_rgb888

Pipelined 3x3 convolution stage that consumes the nine RGB888 window taps and tap-valid strobe produced by the 3x3 window generator, and emits one filtered RGB888 pixel per valid window. One programmable signed 3x3 kernel is applied independently to the R, G and B channels. Each result is normalised by a fixed right shift and clamped to 0..255. A frame counter flags the last output pixel of each frame. The block sits between the window generator and the downstream feature/output logic in the CNN top level.

## Interface
- DATA_W, 24, pixel width; packing [23:16]=R, [15:8]=G, [7:0]=B
- COEF_W, 8, signed kernel coefficient width
- SHIFT, 4, arithmetic right shift applied to each channel sum
- OUT_PER_FRAME, 129060, valid outputs per frame (478x270 windows)
- CNT_W, 17, frame counter width

- iClk  in  1  clock; all logic on rising edge
- iRst  in  1  reset, asynchronous, active-high
- iIn0..iIn8  in  24 each  window taps, row-major: iIn0 top-left, iIn4 centre, iIn8 bottom-right
- iValid  in  1  taps valid this cycle
- iCoefWe  in  1  coefficient write strobe
- iCoefAddr  in  4  coefficient index 0..8, same row-major order as taps
- iCoefData  in  8  signed coefficient value
- oPixel  out  24  filtered RGB888 pixel
- oValid  out  1  oPixel valid, one-cycle strobe per input valid
- oFrameDone  out  1  one-cycle pulse coincident with the last oValid of a frame

## Operation
- Coefficient bank: nine signed 8-bit registers K0..K8.
  - Reset value: all 0 except K4 = 16. With SHIFT=4 this gives an identity filter.
  - iCoefWe=1 writes iCoefData to K[iCoefAddr]. Addresses 9..15 are ignored with no side effect.
- Per channel c in {R,G,B}:
  - sum_c = Σ Ki × pixel_i,c, with each pixel zero-extended to 9-bit signed.
  - Each product is 17-bit signed; the full sum is 21-bit signed with no overflow possible.
  - out_c = sum_c >>> SHIFT (arithmetic, truncation toward −inf), then clamped: <0 → 0, >255 → 255, else the low 8 bits.
- Pipeline, 4 stages, no stall, valid bit carried alongside data:
  - S1: register the 27 products.
  - S2: register three row sums per channel.
  - S3: register the final 21-bit sum per channel.
  - S4: shift and clamp into oPixel; oValid asserted.
- Bubbles: cycles with iValid=0 are bubbles. oValid=0 at the matching output slot. oPixel holds its last valid value when oValid=0.
- Frame counter:
  - Increments on each oValid.
  - When the count equals OUT_PER_FRAME−1 and oValid is asserted, oFrameDone=1 in the same cycle and the counter returns to 0.
- Coefficient write in the same cycle as iValid: S1 for that input uses the old coefficients. The new coefficients apply from the next iValid onward. A window already in S2..S4 is never affected.

## Timing
- Latency: iValid at edge N gives oValid at edge N+4. Sustained throughput is 1 pixel/cycle.
- Reset (asynchronous, takes effect immediately):
  - oPixel=0, oValid=0, oFrameDone=0.
  - Frame counter=0, all pipeline valid bits=0, coefficients return to their reset values.
- Reset asserted mid-frame: windows in flight are discarded. No oValid appears for them after reset release, and counting restarts from 0.
- First iValid accepted is the one sampled at the first rising edge after iRst deasserts.
- Back-to-back frames: the counter wraps seamlessly. The first oValid after an oFrameDone is pixel 0 of the next frame.

## Test plan
- Reset identity kernel: all taps 0x123456, iValid=1 for one cycle → 4 cycles later oPixel=0x123456, oValid=1 for exactly one cycle, then oValid=0.
- Uniform kernel: write K0..K8=2, all taps 0x101010 → oPixel=0x121212 (18×16=288, 288>>4=18).
- Saturation/negative clamp:
  - K all 16, taps 0xFFFFFF → oPixel=0xFFFFFF.
  - K4=−16 and others 0, taps 0x80FF01 → oPixel=0x000000.
- Edge kernel and ordering: K4=16·8/… simplified as K=−2 except K4=16, centre tap 0x400000, other taps 0 → R=(16·64)>>4=64, so oPixel=0x400000. Then set only iIn0 to 0x080000 → R=(1024−16)>>4=63, giving 0x3F0000.
- Write/valid collision: iCoefWe (K4=32) and iValid on the same edge with taps 0x010101 → that output is 0x010101. The next valid with the same taps → 0x020202. A write to address 12 leaves all outputs unchanged.
- Frame and reset: with OUT_PER_FRAME=4, stream 10 valids with 2 bubbles inserted → oFrameDone on output valids 4 and 8 only. Assert iRst after valid 2 of a new stream → oValid/oFrameDone drop at once, no stale outputs appear, and oFrameDone next fires on the 4th valid after release.

Source files
------------

// File: rtl/conv3x3_rgb888_if.sv
// Tap/result bus between the 3x3 window generator, the convolution stage and
// the downstream logic.
//   iIn0..iIn8  : window taps, row-major (iIn0 top-left, iIn4 centre)
//   iValid      : taps valid this cycle
//   iCoefWe/Addr/Data : kernel coefficient write port
//   oPixel/oValid/oFrameDone : filtered pixel, its strobe, last-of-frame pulse
// master drives taps and coefficients; slave is the convolution stage.
interface conv3x3_rgb888_if #(
   parameter int unsigned DATA_W = 24,
   parameter int unsigned COEF_W = 8
);
   logic [DATA_W-1:0] iIn0, iIn1, iIn2, iIn3, iIn4, iIn5, iIn6, iIn7, iIn8;
   logic              iValid;
   logic              iCoefWe;
   logic [3:0]        iCoefAddr;
   logic [COEF_W-1:0] iCoefData;
   logic [DATA_W-1:0] oPixel;
   logic              oValid;
   logic              oFrameDone;

   modport master (
      output iIn0, iIn1, iIn2, iIn3, iIn4, iIn5, iIn6, iIn7, iIn8,
      output iValid, iCoefWe, iCoefAddr, iCoefData,
      input  oPixel, oValid, oFrameDone
   );

   modport slave (
      input  iIn0, iIn1, iIn2, iIn3, iIn4, iIn5, iIn6, iIn7, iIn8,
      input  iValid, iCoefWe, iCoefAddr, iCoefData,
      output oPixel, oValid, oFrameDone
   );
endinterface

// File: rtl/conv3x3_rgb888.sv
// Four-stage pipelined 3x3 convolution over RGB888 windows. One programmable
// signed kernel is applied to each colour channel, the sums are shifted right
// by SHIFT and clamped to 0..255. A frame counter pulses oFrameDone with the
// last output pixel of each frame.
//   iClk, iRst : clock and asynchronous active-high reset
//   bus        : taps, tap valid, coefficient write port, pixel outputs
module conv3x3_rgb888 #(
   parameter int unsigned DATA_W        = 24,
   parameter int unsigned COEF_W        = 8,
   parameter int unsigned SHIFT         = 4,
   parameter int unsigned OUT_PER_FRAME = 129060,
   parameter int unsigned CNT_W         = 17
) (
   input  logic                  iClk,
   input  logic                  iRst,
   conv3x3_rgb888_if.slave       bus
);
   localparam int unsigned NTAP   = 9;
   localparam int unsigned NCH    = 3;
   localparam int unsigned CH_W   = 8;
   localparam int unsigned PROD_W = CH_W + 1 + COEF_W;
   localparam int unsigned ROW_W  = PROD_W + 2;
   localparam int unsigned SUM_W  = PROD_W + 4;

   logic [DATA_W-1:0]        taps [NTAP];
   logic signed [COEF_W-1:0] coef [NTAP];
   logic signed [PROD_W-1:0] prod [NCH][NTAP];
   logic signed [ROW_W-1:0]  rowSum [NCH][3];
   logic signed [SUM_W-1:0]  chSum [NCH];
   logic                     v1, v2, v3;
   logic [CNT_W-1:0]         frameCnt;
   logic [DATA_W-1:0]        pixNext;

   assign taps[0] = bus.iIn0;
   assign taps[1] = bus.iIn1;
   assign taps[2] = bus.iIn2;
   assign taps[3] = bus.iIn3;
   assign taps[4] = bus.iIn4;
   assign taps[5] = bus.iIn5;
   assign taps[6] = bus.iIn6;
   assign taps[7] = bus.iIn7;
   assign taps[8] = bus.iIn8;

   // Coefficient bank; resets to the identity kernel (centre = 1 << SHIFT).
   // Addresses beyond the last tap match no register and are dropped.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         for (int i = 0; i < NTAP; i++)
            coef[i] <= (i == 4) ? COEF_W'(1 << SHIFT) : '0;
      end else if (bus.iCoefWe) begin
         for (int i = 0; i < NTAP; i++)
            if (bus.iCoefAddr == 4'(i))
               coef[i] <= bus.iCoefData;
      end
   end

   // Datapath S1..S3: products, row sums, channel sums. Unreset; validity is
   // tracked separately so stale data is never presented.
   always_ff @(posedge iClk) begin
      for (int c = 0; c < NCH; c++) begin
         for (int i = 0; i < NTAP; i++)
            prod[c][i] <= PROD_W'($signed({1'b0, taps[i][DATA_W-CH_W*(c+1) +: CH_W]}))
                        * PROD_W'(coef[i]);
         for (int r = 0; r < 3; r++)
            rowSum[c][r] <= ROW_W'(prod[c][3*r]) + ROW_W'(prod[c][3*r+1])
                          + ROW_W'(prod[c][3*r+2]);
         chSum[c] <= SUM_W'(rowSum[c][0]) + SUM_W'(rowSum[c][1]) + SUM_W'(rowSum[c][2]);
      end
   end

   // Normalise and clamp each channel; sign bit means negative, any set bit
   // above the low byte means the value exceeds 255.
   always_comb begin
      logic signed [SUM_W-1:0] sh;
      logic [CH_W-1:0]         chOut;
      pixNext = '0;
      sh      = '0;
      chOut   = '0;
      for (int c = 0; c < NCH; c++) begin
         sh = chSum[c] >>> SHIFT;
         if (sh[SUM_W-1])
            chOut = '0;
         else if (|sh[SUM_W-2:CH_W])
            chOut = '1;
         else
            chOut = sh[CH_W-1:0];
         pixNext[DATA_W-CH_W*(c+1) +: CH_W] = chOut;
      end
   end

   // Valid pipeline, S4 output register and frame counter.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         v1             <= 1'b0;
         v2             <= 1'b0;
         v3             <= 1'b0;
         bus.oValid     <= 1'b0;
         bus.oFrameDone <= 1'b0;
         bus.oPixel     <= '0;
         frameCnt       <= '0;
      end else begin
         v1             <= bus.iValid;
         v2             <= v1;
         v3             <= v2;
         bus.oValid     <= v3;
         bus.oFrameDone <= 1'b0;
         if (v3) begin
            bus.oPixel <= pixNext;
            if (frameCnt == CNT_W'(OUT_PER_FRAME - 1)) begin
               bus.oFrameDone <= 1'b1;
               frameCnt       <= '0;
            end else begin
               frameCnt <= frameCnt + CNT_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_conv3x3_rgb888.sv
// Bench for conv3x3_rgb888: directed literal cases plus randomized traffic,
// all compared every cycle against an arithmetic reference model.
module tb_conv3x3_rgb888;
   localparam int unsigned OPF = 4;

   typedef logic [8:0][23:0] taps_t;

   logic iClk;
   logic iRst;

   conv3x3_rgb888_if bus ();

   conv3x3_rgb888 #(.OUT_PER_FRAME(OPF)) dut (
      .iClk (iClk),
      .iRst (iRst),
      .bus  (bus)
   );

   initial begin
      iClk = 1'b0;
      forever #5 iClk = ~iClk;
   end

   int          nChecks;
   int          nFails;
   logic        expValid, expDone;
   logic [23:0] expPix;
   logic        sV, sDone;
   logic [23:0] sPix;
   logic        monClr;
   int          vIdx;
   logic [31:0] doneMask;

   // Reference arithmetic: signed kernel dot product per channel, floor shift, clamp.
   function automatic logic [23:0] modelPix(input taps_t t, input int k [9]);
      logic [23:0] r;
      int s;
      r = '0;
      for (int c = 0; c < 3; c++) begin
         s = 0;
         for (int i = 0; i < 9; i++)
            s += k[i] * int'(t[i][8*(2-c) +: 8]);
         s = s >>> 4;
         if (s < 0) s = 0;
         else if (s > 255) s = 255;
         r[8*(2-c) +: 8] = 8'(s);
      end
      return r;
   endfunction

   function automatic taps_t curTaps();
      taps_t t;
      t[0] = bus.iIn0; t[1] = bus.iIn1; t[2] = bus.iIn2;
      t[3] = bus.iIn3; t[4] = bus.iIn4; t[5] = bus.iIn5;
      t[6] = bus.iIn6; t[7] = bus.iIn7; t[8] = bus.iIn8;
      return t;
   endfunction

   function automatic taps_t allTaps(input logic [23:0] v);
      taps_t t;
      for (int i = 0; i < 9; i++) t[i] = v;
      return t;
   endfunction

   // Reference model: a window sampled at edge E emerges at edge E+3
   // (four edges after the edge at which it was driven).
   int          mCoef [9];
   logic        lineV [4];
   logic [23:0] lineP [4];
   int          mCnt;
   initial begin
      forever begin
         @(posedge iClk or posedge iRst);
         if (iRst) begin
            for (int k = 0; k < 4; k++) begin lineV[k] = 1'b0; lineP[k] = '0; end
            for (int i = 0; i < 9; i++) mCoef[i] = (i == 4) ? 16 : 0;
            mCnt = 0; expValid = 1'b0; expDone = 1'b0; expPix = '0;
         end else begin
            for (int k = 3; k > 0; k--) begin lineV[k] = lineV[k-1]; lineP[k] = lineP[k-1]; end
            lineV[0] = bus.iValid;
            lineP[0] = modelPix(curTaps(), mCoef);
            if (bus.iCoefWe && bus.iCoefAddr < 4'd9)
               mCoef[bus.iCoefAddr] = int'($signed(bus.iCoefData));
            expValid = lineV[3];
            expDone  = 1'b0;
            if (lineV[3]) begin
               expPix = lineP[3];
               if (mCnt == OPF - 1) begin expDone = 1'b1; mCnt = 0; end
               else mCnt++;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: sample and compare at the falling edge, then return just
   // after the next rising edge, where inputs are driven.
   task automatic cycle();
      @(negedge iClk);
      sV    = bus.oValid;
      sDone = bus.oFrameDone;
      sPix  = bus.oPixel;
      check("model_oValid", 32'(sV), 32'(expValid));
      check("model_oFrameDone", 32'(sDone), 32'(expDone));
      check("model_oPixel", 32'(sPix), 32'(expPix));
      if (monClr) begin
         vIdx = 0; doneMask = '0;
      end else if (sV) begin
         vIdx++;
         if (sDone && vIdx < 32) doneMask[vIdx] = 1'b1;
      end
      @(posedge iClk);
      #1;
   endtask

   task automatic setTaps(input taps_t t);
      bus.iIn0 = t[0]; bus.iIn1 = t[1]; bus.iIn2 = t[2];
      bus.iIn3 = t[3]; bus.iIn4 = t[4]; bus.iIn5 = t[5];
      bus.iIn6 = t[6]; bus.iIn7 = t[7]; bus.iIn8 = t[8];
   endtask

   task automatic writeCoef(input logic [3:0] a, input logic [7:0] d);
      bus.iCoefWe = 1'b1; bus.iCoefAddr = a; bus.iCoefData = d;
      cycle();
      bus.iCoefWe = 1'b0;
   endtask

   task automatic doReset();
      iRst = 1'b1; monClr = 1'b1;
      cycle(); cycle();
      iRst = 1'b0; monClr = 1'b0;
   endtask

   // Single window, optionally with a same-edge coefficient write; checks
   // latency, literal pixel value and one-cycle strobe width.
   task automatic sendOne(input taps_t t, input logic we, input logic [3:0] a,
                          input logic [7:0] d, input logic [23:0] lit, input string name);
      int got;
      logic [23:0] gotPix;
      setTaps(t);
      bus.iValid = 1'b1; bus.iCoefWe = we; bus.iCoefAddr = a; bus.iCoefData = d;
      cycle();
      bus.iValid = 1'b0; bus.iCoefWe = 1'b0;
      got = 0; gotPix = '0;
      for (int k = 1; k <= 8; k++) begin
         cycle();
         if (sV) begin got = k; gotPix = sPix; break; end
      end
      check({name, "_latency"}, 32'(got), 32'd4);
      check({name, "_pixel"}, 32'(gotPix), 32'(lit));
      cycle();
      check({name, "_strobe"}, 32'(sV), 32'd0);
   endtask

   initial begin
      taps_t t;
      nChecks = 0; nFails = 0; vIdx = 0; doneMask = '0; monClr = 1'b1;
      iRst = 1'b1;
      bus.iValid = 1'b0; bus.iCoefWe = 1'b0; bus.iCoefAddr = '0; bus.iCoefData = '0;
      setTaps(allTaps(24'h0));
      @(posedge iClk); #1;
      cycle(); cycle();
      check("rst_oPixel", 32'(sPix), 32'd0);
      check("rst_oValid", 32'(sV), 32'd0);
      check("rst_oFrameDone", 32'(sDone), 32'd0);
      iRst = 1'b0; monClr = 1'b0;

      // Identity kernel out of reset.
      sendOne(allTaps(24'h123456), 1'b0, 4'd0, 8'd0, 24'h123456, "identity");

      // Uniform kernel of 2.
      for (int i = 0; i < 9; i++) writeCoef(4'(i), 8'd2);
      sendOne(allTaps(24'h101010), 1'b0, 4'd0, 8'd0, 24'h121212, "uniform");

      // Saturation high.
      for (int i = 0; i < 9; i++) writeCoef(4'(i), 8'd16);
      sendOne(allTaps(24'hFFFFFF), 1'b0, 4'd0, 8'd0, 24'hFFFFFF, "sat_high");

      // Negative clamp.
      for (int i = 0; i < 9; i++) writeCoef(4'(i), 8'd0);
      writeCoef(4'd4, 8'hF0);
      sendOne(allTaps(24'h80FF01), 1'b0, 4'd0, 8'd0, 24'h000000, "sat_low");

      // Edge kernel: -2 around a centre of 16; checks tap ordering.
      for (int i = 0; i < 9; i++) writeCoef(4'(i), (i == 4) ? 8'd16 : 8'hFE);
      t = allTaps(24'h0);
      t[4] = 24'h400000;
      sendOne(t, 1'b0, 4'd0, 8'd0, 24'h400000, "edge_centre");
      t[0] = 24'h080000;
      sendOne(t, 1'b0, 4'd0, 8'd0, 24'h3F0000, "edge_topleft");

      // Coefficient write colliding with a valid window.
      doReset();
      sendOne(allTaps(24'h010101), 1'b1, 4'd4, 8'd32, 24'h010101, "collide_old");
      sendOne(allTaps(24'h010101), 1'b0, 4'd0, 8'd0, 24'h020202, "collide_new");
      writeCoef(4'd12, 8'h55);
      sendOne(allTaps(24'h010101), 1'b0, 4'd0, 8'd0, 24'h020202, "bad_addr");

      // Frame pulses: 10 valids with two bubbles.
      doReset();
      for (int j = 0; j < 12; j++) begin
         setTaps(allTaps(24'($urandom)));
         bus.iValid = (j != 3 && j != 8);
         cycle();
      end
      bus.iValid = 1'b0;
      for (int j = 0; j < 6; j++) cycle();
      check("frame_count", 32'(vIdx), 32'd10);
      check("frame_done_mask", doneMask, 32'h110);

      // Reset while outputs are in flight.
      doReset();
      for (int j = 0; j < 5; j++) begin
         setTaps(allTaps(24'($urandom)));
         bus.iValid = 1'b1;
         cycle();
      end
      check("pre_rst_valid", 32'(sV), 32'd1);
      bus.iValid = 1'b0;
      iRst = 1'b1; monClr = 1'b1;
      #1;
      check("async_rst_valid", 32'(bus.oValid), 32'd0);
      check("async_rst_done", 32'(bus.oFrameDone), 32'd0);
      check("async_rst_pixel", 32'(bus.oPixel), 32'd0);
      cycle(); cycle();
      iRst = 1'b0; monClr = 1'b0;
      for (int j = 0; j < 4; j++) begin
         setTaps(allTaps(24'($urandom)));
         bus.iValid = 1'b1;
         cycle();
      end
      bus.iValid = 1'b0;
      for (int j = 0; j < 6; j++) cycle();
      check("post_rst_count", 32'(vIdx), 32'd4);
      check("post_rst_done_mask", doneMask, 32'h10);

      // Randomized traffic with interleaved coefficient writes.
      for (int j = 0; j < 1500; j++) begin
         for (int i = 0; i < 9; i++) t[i] = 24'($urandom);
         setTaps(t);
         bus.iValid    = ($urandom_range(0, 3) != 0);
         bus.iCoefWe   = ($urandom_range(0, 7) == 0);
         bus.iCoefAddr = 4'($urandom_range(0, 15));
         bus.iCoefData = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 8))
                                                      : 8'($urandom);
         cycle();
      end
      bus.iValid = 1'b0; bus.iCoefWe = 1'b0;
      for (int j = 0; j < 6; j++) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
      $finish;
   end
endmodule
